// File: rtl/stack_seq_pkg.sv
// Shared constants for the subroutine call/return sequencer: op codes,
// fault codes, state encodings and default stack geometry.
package stack_seq_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DEPTH_DEF  = 8;

  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_RET  = 2'b10;

  localparam logic [2:0] FLT_NONE  = 3'd0;
  localparam logic [2:0] FLT_OVF   = 3'd1;
  localparam logic [2:0] FLT_UNF   = 3'd2;
  localparam logic [2:0] FLT_BADOP = 3'd3;
  localparam logic [2:0] FLT_NOACK = 3'd4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PUSH  = 3'd1;
  localparam logic [2:0] S_JUMP  = 3'd2;
  localparam logic [2:0] S_POP   = 3'd3;
  localparam logic [2:0] S_RETLD = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

endpackage

// File: rtl/stack_seq_ctrl.sv
// Call/return sequencer between decoder, PC stack and PC: guards stack depth,
// strobes push/pop and loads PC (and accumulator on return).
module stack_seq_ctrl
  import stack_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int SP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [1:0]        reqOp,
  input  logic [ADDR_W-1:0] reqTarget,
  input  logic [ADDR_W-1:0] reqRetAddr,
  input  logic [3:0]        reqData,
  output logic              stkPush,
  output logic              stkPop,
  output logic [ADDR_W-1:0] stkPcIn,
  input  logic [ADDR_W-1:0] stkPcOut,
  input  logic [SP_W-1:0]   stkSp,
  input  logic              stkPcLoad,
  output logic              pcLoad,
  output logic [ADDR_W-1:0] pcLoadAddr,
  output logic              accLoad,
  output logic [3:0]        accData,
  output logic              doneValid,
  output logic [2:0]        faultCode,
  input  logic              faultClr
);

  localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH - 1);
  localparam logic [SP_W-1:0] SP_MIN = '0;

  logic [2:0]        state;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_target;
  logic [ADDR_W-1:0] req_ret_addr;
  logic [3:0]        req_data;
  logic [ADDR_W-1:0] ret_reg;
  logic [2:0]        pend_fault;

  assign reqReady = (state == S_IDLE) && !rst;

  // All strobes default low each cycle so every one is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req_op       <= '0;
      req_target   <= '0;
      req_ret_addr <= '0;
      req_data     <= '0;
      ret_reg      <= '0;
      pend_fault   <= FLT_NONE;
      stkPush      <= 1'b0;
      stkPop       <= 1'b0;
      stkPcIn      <= '0;
      pcLoad       <= 1'b0;
      pcLoadAddr   <= '0;
      accLoad      <= 1'b0;
      accData      <= '0;
      doneValid    <= 1'b0;
      faultCode    <= FLT_NONE;
    end else begin
      stkPush    <= 1'b0;
      stkPop     <= 1'b0;
      stkPcIn    <= '0;
      pcLoad     <= 1'b0;
      pcLoadAddr <= '0;
      accLoad    <= 1'b0;
      accData    <= '0;
      doneValid  <= 1'b0;

      if (faultClr) begin
        faultCode <= FLT_NONE;
      end

      case (state)
        S_IDLE: begin
          if (reqValid) begin
            req_op       <= reqOp;
            req_target   <= reqTarget;
            req_ret_addr <= reqRetAddr;
            req_data     <= reqData;
            // Depth is checked here so the stack's own error flags never fire.
            if (reqOp == OP_CALL) begin
              if (stkSp == SP_MAX) begin
                pend_fault <= FLT_OVF;
                state      <= S_FAULT;
              end else begin
                state <= S_PUSH;
              end
            end else if (reqOp == OP_RET) begin
              if (stkSp == SP_MIN) begin
                pend_fault <= FLT_UNF;
                state      <= S_FAULT;
              end else begin
                state <= S_POP;
              end
            end else begin
              pend_fault <= FLT_BADOP;
              state      <= S_FAULT;
            end
          end
        end
        S_PUSH: begin
          stkPush <= 1'b1;
          stkPcIn <= req_ret_addr;
          state   <= S_JUMP;
        end
        S_JUMP: begin
          pcLoad     <= 1'b1;
          pcLoadAddr <= req_target;
          doneValid  <= 1'b1;
          state      <= S_IDLE;
        end
        S_POP: begin
          stkPop  <= 1'b1;
          ret_reg <= stkPcOut;
          state   <= S_RETLD;
        end
        S_RETLD: begin
          if (stkPcLoad) begin
            pcLoad     <= 1'b1;
            pcLoadAddr <= ret_reg;
            accLoad    <= 1'b1;
            accData    <= req_data;
            doneValid  <= 1'b1;
            state      <= S_IDLE;
          end else begin
            pend_fault <= FLT_NOACK;
            state      <= S_FAULT;
          end
        end
        S_FAULT: begin
          doneValid <= 1'b1;
          // First fault sticks; a clear in the same cycle loses to the new fault.
          if (faultCode == FLT_NONE || faultClr) begin
            faultCode <= pend_fault;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Self-checking bench for stack_seq_ctrl: directed scenarios plus random
// call/return traffic against a queue-based model with an attached stack.
module tb_stack_seq_ctrl;
  import stack_seq_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 8;
  localparam int SPW   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqValid;
  logic          reqReady;
  logic [1:0]    reqOp;
  logic [AW-1:0] reqTarget;
  logic [AW-1:0] reqRetAddr;
  logic [3:0]    reqData;
  logic          stkPush;
  logic          stkPop;
  logic [AW-1:0] stkPcIn;
  logic [AW-1:0] stkPcOut;
  logic [SPW-1:0] stkSp;
  logic          stkPcLoad;
  logic          pcLoad;
  logic [AW-1:0] pcLoadAddr;
  logic          accLoad;
  logic [3:0]    accData;
  logic          doneValid;
  logic [2:0]    faultCode;
  logic          faultClr;

  stack_seq_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .SP_W(SPW)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
    .reqTarget(reqTarget), .reqRetAddr(reqRetAddr), .reqData(reqData),
    .stkPush(stkPush), .stkPop(stkPop), .stkPcIn(stkPcIn),
    .stkPcOut(stkPcOut), .stkSp(stkSp), .stkPcLoad(stkPcLoad),
    .pcLoad(pcLoad), .pcLoadAddr(pcLoadAddr),
    .accLoad(accLoad), .accData(accData),
    .doneValid(doneValid), .faultCode(faultCode), .faultClr(faultClr)
  );

  always #5 clk = ~clk;

  // Attached PC stack: level 0 is the base PC, the top entry sits at sp.
  logic [AW-1:0]  stk_mem [0:DEPTH-1];
  logic [SPW-1:0] sp;
  logic           ovf_flag, unf_flag, stk_clear, force_noack;

  assign stkSp     = sp;
  assign stkPcOut  = stk_mem[sp];
  assign stkPcLoad = stkPop && !force_noack && (sp != 0);

  always @(posedge clk) begin
    if (stk_clear) begin
      sp       <= '0;
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_mem[i] <= '0;
    end else begin
      if (stkPush) begin
        if (sp == SPW'(DEPTH - 1)) ovf_flag <= 1'b1;
        else begin
          stk_mem[sp + 3'd1] <= stkPcIn;
          sp <= sp + 3'd1;
        end
      end
      if (stkPop) begin
        if (sp == 0) unf_flag <= 1'b1;
        else sp <= sp - 3'd1;
      end
    end
  end

  logic [AW-1:0] exp_stack [$];
  int exp_fault;
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic waitReady();
    int n = 0;
    @(negedge clk);
    while (!reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_before_req", {31'd0, reqReady}, 32'd1);
  endtask

  // Drives one request and checks the cycle-by-cycle outcome against the model.
  task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] target,
                               input logic [AW-1:0] ret_addr, input logic [3:0] data,
                               input bit noack);
    int e_push_c = 0, e_pop_c = 0, e_pcl_c = 0, e_acc_c = 0, e_done_c = 0, e_flt = 0;
    logic [AW-1:0] e_pcin = '0, e_pcaddr = '0;
    int n_push = 0, n_pop = 0, n_pcl = 0, n_acc = 0, n_done = 0, n_clash = 0;
    int c_push = 0, c_pop = 0, c_pcl = 0, c_acc = 0, c_done = 0;
    logic [AW-1:0] v_pcin = '0, v_pcaddr = '0;
    logic [3:0] v_acc = '0;
    int depth = exp_stack.size();

    if (op == OP_CALL) begin
      if (depth == DEPTH - 1) begin
        e_done_c = 2; e_flt = 1;
      end else begin
        e_push_c = 2; e_pcin = ret_addr;
        e_pcl_c = 3; e_pcaddr = target; e_done_c = 3;
        exp_stack.push_back(ret_addr);
      end
    end else if (op == OP_RET) begin
      if (depth == 0) begin
        e_done_c = 2; e_flt = 2;
      end else begin
        e_pop_c = 2;
        e_pcaddr = exp_stack.pop_back();
        if (noack) begin
          e_done_c = 4; e_flt = 4;
        end else begin
          e_pcl_c = 3; e_acc_c = 3; e_done_c = 3;
        end
      end
    end else begin
      e_done_c = 2; e_flt = 3;
    end
    if (e_flt != 0 && exp_fault == 0) exp_fault = e_flt;

    waitReady();
    force_noack = noack;
    reqValid = 1'b1; reqOp = op; reqTarget = target; reqRetAddr = ret_addr; reqData = data;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        reqValid   = 1'b0;
        reqOp      = 2'($urandom);
        reqTarget  = AW'($urandom);
        reqRetAddr = AW'($urandom);
        reqData    = 4'($urandom);
      end
      if (stkPush) begin n_push++; c_push = c; v_pcin = stkPcIn; end
      if (stkPop) begin n_pop++; c_pop = c; end
      if (pcLoad) begin n_pcl++; c_pcl = c; v_pcaddr = pcLoadAddr; end
      if (accLoad) begin n_acc++; c_acc = c; v_acc = accData; end
      if (doneValid) begin n_done++; c_done = c; end
      if ((stkPush && stkPop) || (stkPush && pcLoad)) n_clash++;
    end
    force_noack = 1'b0;

    checkOutput("push_count", n_push, (e_push_c != 0) ? 1 : 0);
    checkOutput("pop_count", n_pop, (e_pop_c != 0) ? 1 : 0);
    checkOutput("pcload_count", n_pcl, (e_pcl_c != 0) ? 1 : 0);
    checkOutput("accload_count", n_acc, (e_acc_c != 0) ? 1 : 0);
    checkOutput("done_count", n_done, 1);
    checkOutput("done_cycle", c_done, e_done_c);
    checkOutput("strobe_clash", n_clash, 0);
    if (e_push_c != 0) begin
      checkOutput("push_cycle", c_push, e_push_c);
      checkOutput("push_value", v_pcin, e_pcin);
    end
    if (e_pop_c != 0) checkOutput("pop_cycle", c_pop, e_pop_c);
    if (e_pcl_c != 0) begin
      checkOutput("pcload_cycle", c_pcl, e_pcl_c);
      checkOutput("pcload_addr", v_pcaddr, e_pcaddr);
    end
    if (e_acc_c != 0) begin
      checkOutput("accload_cycle", c_acc, e_acc_c);
      checkOutput("acc_data", v_acc, data);
    end
    checkOutput("fault_code", faultCode, exp_fault);
  endtask

  task automatic clearFault();
    @(negedge clk);
    faultClr = 1'b1;
    @(negedge clk);
    faultClr = 1'b0;
    exp_fault = 0;
    checkOutput("fault_clear", faultCode, 0);
  endtask

  task automatic resetDuringPush();
    int n_done = 0, n_push = 0;
    waitReady();
    reqValid = 1'b1; reqOp = OP_CALL; reqTarget = 12'h7C0; reqRetAddr = 12'h055; reqData = 4'h0;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_strobes", {27'd0, stkPush, stkPop, pcLoad, accLoad, doneValid}, 0);
    checkOutput("abort_ready_in_rst", reqReady, 0);
    rst = 1'b0;
    exp_fault = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) checkOutput("abort_ready_after", reqReady, 1);
      if (doneValid) n_done++;
      if (stkPush) n_push++;
    end
    checkOutput("abort_no_done", n_done, 0);
    checkOutput("abort_no_push", n_push, 0);
    checkOutput("abort_fault", faultCode, 0);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0] op;
    rst = 1'b1; stk_clear = 1'b1; force_noack = 1'b0; faultClr = 1'b0;
    reqValid = 1'b0; reqOp = '0; reqTarget = '0; reqRetAddr = '0; reqData = '0;
    exp_fault = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_strobes", {27'd0, stkPush, stkPop, pcLoad, accLoad, doneValid}, 0);
    checkOutput("reset_addr", {8'd0, pcLoadAddr, stkPcIn}, 0);
    checkOutput("reset_ready", reqReady, 0);
    checkOutput("reset_fault", faultCode, 0);
    rst = 1'b0; stk_clear = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", reqReady, 1);

    applyStimulus(OP_CALL, 12'h3A0, 12'h012, 4'h0, 1'b0);
    applyStimulus(OP_RET, 12'h000, 12'h000, 4'h5, 1'b0);

    for (int i = 0; i < 8; i++)
      applyStimulus(OP_CALL, AW'(12'h100 + i), AW'(12'h200 + i), 4'h0, 1'b0);
    checkOutput("nest_no_overflow", ovf_flag, 0);
    for (int i = 0; i < 7; i++)
      applyStimulus(OP_RET, 12'h000, 12'h000, 4'(i), 1'b0);
    clearFault();

    applyStimulus(OP_CALL, 12'h2B0, 12'h145, 4'h0, 1'b0);
    applyStimulus(OP_RET, 12'h000, 12'h000, 4'h9, 1'b0);

    applyStimulus(OP_RET, 12'h000, 12'h000, 4'h1, 1'b0);
    applyStimulus(OP_CALL, 12'h0F0, 12'h0AA, 4'h0, 1'b0);
    applyStimulus(OP_RET, 12'h000, 12'h000, 4'h2, 1'b0);
    clearFault();

    applyStimulus(2'b11, 12'h000, 12'h000, 4'h0, 1'b0);
    applyStimulus(2'b00, 12'h000, 12'h000, 4'h0, 1'b0);
    applyStimulus(OP_CALL, 12'h321, 12'h123, 4'h0, 1'b0);
    applyStimulus(OP_RET, 12'h000, 12'h000, 4'h3, 1'b1);
    clearFault();
    applyStimulus(OP_CALL, 12'h654, 12'h456, 4'h0, 1'b0);
    applyStimulus(OP_RET, 12'h000, 12'h000, 4'h4, 1'b1);
    clearFault();

    resetDuringPush();

    for (int n = 0; n < 80; n++) begin
      int r = $urandom_range(0, 9);
      if (r < 5) op = OP_CALL;
      else if (r < 9) op = OP_RET;
      else op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      applyStimulus(op, AW'($urandom), AW'($urandom), 4'($urandom),
                    ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 7) == 0) clearFault();
    end

    checkOutput("stack_overflow_flag", ovf_flag, 0);
    checkOutput("stack_underflow_flag", unf_flag, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_seq_ctrl.md
Name: stack_seq_ctrl

Overview:
Sequencer for subroutine call/return traffic into the 8-level PC stack: JMS-style CALL and BBL-style RET.
- Accepts one request at a time from the decoder over a valid/ready handshake.
- Drives the stack's push/pop strobes and loads the PC with the target or return address; on RET it also loads the accumulator with the BBL data nibble.
- Checks stack depth before every action, so the stack's own overflow/underflow flags never fire; lives in cpuTop between decoder, stack and PC.

Parameters:
ADDR_W, 12, PC/stack address width
DEPTH, 8, stack entries; usable nesting = DEPTH-1 (level 0 is the base PC)
SP_W, 3, width of stack pointer = clog2(DEPTH)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
reqValid  input  1  request present
reqReady  output  1  controller can accept (high only in IDLE and rst low)
reqOp  input  2  01 CALL, 10 RET, 00/11 illegal
reqTarget  input  ADDR_W  CALL jump target
reqRetAddr  input  ADDR_W  CALL return address (next instr)
reqData  input  4  RET accumulator nibble
stkPush  output  1  stack push strobe
stkPop  output  1  stack pop strobe
stkPcIn  output  ADDR_W  value pushed
stkPcOut  input  ADDR_W  stack top (combinational from stack)
stkSp  input  SP_W  current stack pointer
stkPcLoad  input  1  stack's 1-cycle pop-complete pulse
pcLoad  output  1  PC load strobe, 1 cycle
pcLoadAddr  output  ADDR_W  PC load value
accLoad  output  1  accumulator load strobe, 1 cycle
accData  output  4  accumulator load value
doneValid  output  1  1-cycle pulse, request finished (ok or fault)
faultCode  output  3  sticky first fault: 0 none, 1 OVF, 2 UNF, 3 BADOP, 4 NOACK
faultClr  input  1  clears faultCode (rst has priority)

Behaviour:
- Reset (rst high at edge): state IDLE; every strobe, doneValid, address and data output goes to 0; faultCode=0; latched request regs=0. reqReady is 0 while rst is high.
- States: IDLE, PUSH, JUMP, POP, RETLD, FAULT. Strobes are registered Moore outputs of the state, so each is high for exactly one cycle.
- IDLE: reqReady=1. Transfer on reqValid&reqReady; latch reqOp, reqTarget, reqRetAddr, reqData.
  - CALL and stkSp==DEPTH-1 -> FAULT(OVF); no push.
  - CALL otherwise -> PUSH.
  - RET and stkSp==0 -> FAULT(UNF); no pop.
  - RET otherwise -> POP.
  - Illegal op -> FAULT(BADOP).
- PUSH: stkPush=1, stkPcIn=latched retAddr -> JUMP.
- JUMP: pcLoad=1, pcLoadAddr=latched target, doneValid=1 -> IDLE. CALL latency: accept edge T, push T+1, pcLoad and done T+2.
- POP: stkPop=1; capture stkPcOut (pre-pop top) into retReg -> RETLD.
- RETLD:
  - stkPcLoad=1: pcLoad=1, pcLoadAddr=retReg, accLoad=1, accData=latched data, doneValid=1 -> IDLE.
  - stkPcLoad=0: FAULT(NOACK), no pcLoad.
  - RET latency: accept T, pop T+1, pcLoad/accLoad/done T+2.
- FAULT: doneValid=1 for one cycle; faultCode is written only if it is currently 0 (first fault sticks) -> IDLE.
- faultClr in the same cycle as a new fault: the new fault wins.
- stkPush and stkPop are never high together; pcLoad and stkPush are never high together.
- Inputs are sampled only in IDLE (request) and POP/RETLD (stack feedback); changes elsewhere are ignored.
- Back-to-back requests: the next request can be accepted in the cycle after done, so throughput is one request per 3 cycles.
- rst mid-operation: aborts the request with no done pulse; strobes are 0 from the next edge.

Decomposition:
- Package stack_seq_pkg holds: state enum, op codes (OP_CALL=2'b01, OP_RET=2'b10), fault code constants, default ADDR_W/DEPTH.
- Single flat module; no sub-module is warranted. The stack itself remains a sibling instance in cpuTop.

Test Plan:
- Reset, then CALL target=0x3A0 retAddr=0x012 with stkSp=0 -> stkPush at T+1 with stkPcIn=0x012; pcLoad at T+2 with addr 0x3A0; doneValid T+2; faultCode 0.
- Nested 7 CALLs (stack model attached), then 8th CALL -> 8th gives faultCode=1, no stkPush, no pcLoad, doneValid once; stack overflow flag stays 0.
- CALL retAddr=0x145, then RET data=0x9 -> stkPop T+1; pcLoad addr=0x145, accLoad, accData=0x9 at T+2.
- RET with stkSp=0 -> faultCode=2, no stkPop; a following CALL still completes; faultClr pulse -> faultCode 0.
- reqOp=2'b11, then reqOp=2'b00 -> both give doneValid; faultCode=3 (first kept); RET with stkPcLoad forced 0 -> no pcLoad, faultCode stays 3; after faultClr repeat -> 4.
- rst asserted in PUSH state -> next edge all strobes 0, reqReady high one cycle after rst drops, no doneValid for the aborted CALL.
